// File: rtl/pin_uart_rx_if.sv
// Receiver-side bundle for pin_uart_rx: serial line in, decoded byte/name strobes out.
// master drives the line and observes results; slave is the receiver.
interface pin_uart_rx_if;
  logic        rx;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [31:0] name;
  logic        name_valid;
  logic        frame_err;

  modport master (
    output rx,
    input  byte_data, byte_valid, name, name_valid, frame_err
  );

  modport slave (
    input  rx,
    output byte_data, byte_valid, name, name_valid, frame_err
  );
endinterface

// File: rtl/pin_uart_rx.sv
// 8N1 UART receiver that assembles groups of four bytes into a 32-bit pin name, first byte in the
// MSBs, and drops a partial name after a long idle gap, a framing error or reset.
module pin_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned IDLE_BITS    = 12
) (
  input logic           clk_i,
  input logic           rst_i,
  pin_uart_rx_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdleW = $clog2(IDLE_BITS * CLKS_PER_BIT);
  localparam logic [CntW-1:0]  HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]  BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [23:0]       nshift_q, nshift_d;
  logic [1:0]        char_cnt_q, char_cnt_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic [31:0]       name_q, name_d;
  logic              byte_valid_q, byte_valid_d;
  logic              name_valid_q, name_valid_d;
  logic              frame_err_q, frame_err_d;

  logic rx_s, half_hit, bit_hit, stop_good, stop_bad;

  assign rx_s      = sync_q[1];
  assign half_hit  = (clk_cnt_q == HalfLast);
  assign bit_hit   = (clk_cnt_q == BitLast);
  assign stop_good = (state_q == StStop) && bit_hit && rx_s;
  assign stop_bad  = (state_q == StStop) && bit_hit && !rx_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!rx_s) state_d = StStart;
      StStart:  if (half_hit) state_d = rx_s ? StIdle : StData;
      StData:   if (bit_hit && (bit_cnt_q == 3'd7)) state_d = StStop;
      StStop:   if (bit_hit) state_d = rx_s ? StIdle : StWaitHi;
      StWaitHi: if (rx_s) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    clk_cnt_d    = clk_cnt_q + CntW'(1);
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    nshift_d     = nshift_q;
    char_cnt_d   = char_cnt_q;
    byte_data_d  = byte_data_q;
    name_d       = name_q;
    byte_valid_d = stop_good;
    name_valid_d = stop_good && (char_cnt_q == 2'd3);
    frame_err_d  = stop_bad;

    unique case (state_q)
      StStart: if (half_hit) begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
      StData: if (bit_hit) begin
        clk_cnt_d = '0;
        shreg_d   = {rx_s, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      StStop:  if (bit_hit) clk_cnt_d = '0;
      default: clk_cnt_d = '0;
    endcase

    // Saturating count of high-line clocks spent waiting for a start bit.
    if ((state_q == StIdle) && rx_s) begin
      idle_cnt_d = (idle_cnt_q == IdleLast) ? idle_cnt_q : idle_cnt_q + IdleW'(1);
    end else begin
      idle_cnt_d = '0;
    end

    if (stop_good) begin
      byte_data_d = shreg_q;
      nshift_d    = {nshift_q[15:0], shreg_q};
      char_cnt_d  = char_cnt_q + 2'd1;
      if (char_cnt_q == 2'd3) name_d = {nshift_q, shreg_q};
    end else if (stop_bad || (idle_cnt_q == IdleLast)) begin
      char_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q       <= 2'b11;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      nshift_q     <= '0;
      char_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      byte_data_q  <= '0;
      name_q       <= '0;
      byte_valid_q <= 1'b0;
      name_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], bus.rx};
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      nshift_q     <= nshift_d;
      char_cnt_q   <= char_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_data_q  <= byte_data_d;
      name_q       <= name_d;
      byte_valid_q <= byte_valid_d;
      name_valid_q <= name_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.name       = name_q;
  assign bus.name_valid = name_valid_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_pin_uart_rx.sv
// Bench for pin_uart_rx: a line driver feeds a bit-time level model whose expected bytes, names and
// framing errors are queued and consumed by an independent output monitor.
module tb_pin_uart_rx;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pin_uart_rx_if bus();

  pin_uart_rx #(.CLKS_PER_BIT(N), .IDLE_BITS(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_names[$];
  int          exp_ferr = 0;
  longint      nv_cyc[$];

  // Reference: four good bytes make a name; a bad stop, reset or a high run of 12+ bit-times
  // since the last line activity drops the partial name.
  logic [31:0] m_acc       = '0;
  int          m_cnt       = 0;
  int          m_run       = 0;
  logic [7:0]  m_last_byte = '0;
  logic [31:0] m_last_name = '0;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", what, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.byte_valid || bus.frame_err)
      check("byte_valid/frame_err exclusive", 32'(bus.byte_valid & bus.frame_err), 0);
    if (bus.byte_valid) begin
      check("byte pending", 32'(exp_bytes.size() != 0), 1);
      if (exp_bytes.size() != 0) check("byte_data", bus.byte_data, exp_bytes.pop_front());
    end
    if (bus.name_valid) begin
      nv_cyc.push_back(cyc);
      check("name pending", 32'(exp_names.size() != 0), 1);
      if (exp_names.size() != 0) check("name", bus.name, exp_names.pop_front());
    end
    if (bus.frame_err) begin
      check("frame_err pending", 32'(exp_ferr != 0), 1);
      if (exp_ferr != 0) exp_ferr--;
    end
  end

  task automatic drive(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    drive(1'b1, bits * N);
    m_run += bits;
    if (m_run >= 12) m_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good);
    m_run = 0;
    if (good) begin
      exp_bytes.push_back(b);
      m_last_byte = b;
      m_acc = {m_acc[23:0], b};
      m_cnt++;
      if (m_cnt == 4) begin
        exp_names.push_back(m_acc);
        m_last_name = m_acc;
        m_cnt = 0;
      end
    end else begin
      exp_ferr++;
      m_cnt = 0;
    end
    drive(1'b0, N);
    for (int i = 0; i < 8; i++) drive(b[i], N);
    drive(good, N);
  endtask

  task automatic send_name(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b1);
  endtask

  task automatic check_reset_outputs();
    check("rst byte_data", bus.byte_data, 0);
    check("rst byte_valid", 32'(bus.byte_valid), 0);
    check("rst name", bus.name, 0);
    check("rst name_valid", 32'(bus.name_valid), 0);
    check("rst frame_err", 32'(bus.frame_err), 0);
  endtask

  initial begin
    int          base;
    int          r;
    logic [7:0]  b;
    int          gaps[7];
    gaps = '{0, 0, 1, 2, 11, 12, 24};

    bus.rx = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    idle(2);

    // "AB12" then three more identical 64-bit periods
    send_name(32'h4142_3132);
    idle(24);
    base = nv_cyc.size();
    repeat (3) begin
      send_name(32'h4142_3132);
      idle(24);
    end
    check("name_valid count", 32'(nv_cyc.size() - base), 3);
    if (base >= 1 && nv_cyc.size() >= base + 3) begin
      for (int i = 0; i < 3; i++)
        check("name period", 32'(nv_cyc[base + i] - nv_cyc[base + i - 1]), 1024);
    end

    // idle glitch, then broken stop bit held low
    drive(1'b0, 4);
    m_run = 0;
    idle(2);
    send_frame(8'h55, 1'b0);
    drive(1'b0, 40);
    idle(2);

    // partial name dropped by a 12 bit-time gap
    send_frame(8'h10, 1'b1);
    send_frame(8'h20, 1'b1);
    idle(12);
    send_name(32'h4142_3132);
    idle(24);

    // reset during DATA of the third byte
    send_frame(8'h50, 1'b1);
    send_frame(8'h51, 1'b1);
    drive(1'b0, N);
    drive(1'b1, N);
    drive(1'b0, N);
    drive(1'b1, N / 2);
    rst = 1'b1;
    m_cnt = 0; m_run = 0; m_last_byte = '0; m_last_name = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    idle(2);
    send_name(32'h7069_6E33);
    idle(24);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom);
      if (r < 7) begin
        send_frame(b, 1'b1);
        idle(gaps[$urandom_range(0, 6)]);
      end else if (r == 7) begin
        send_frame(b, 1'b0);
        drive(1'b0, $urandom_range(0, 40));
        idle(2 + $urandom_range(0, 1));
      end else begin
        idle(2);
        drive(1'b0, $urandom_range(1, 5));
        m_run = 0;
        idle(2);
      end
    end
    idle(24);

    for (int k = 0; k < 400 && (exp_bytes.size() != 0 || exp_names.size() != 0 || exp_ferr != 0);
         k++) @(negedge clk);
    check("bytes left", 32'(exp_bytes.size()), 0);
    check("names left", 32'(exp_names.size()), 0);
    check("frame_err left", 32'(exp_ferr), 0);
    check("byte_data hold", bus.byte_data, m_last_byte);
    check("name hold", bus.name, m_last_name);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
